// File: rtl/twos_comp_arbiter.sv
// Round-robin front end for a shared combinational 16-bit negator: accepts one operand
// at a time, executes it through the external unit and returns the tagged result.
module twos_comp_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      neg_a,
    input  logic [WIDTH-1:0]      neg_b,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_ovf,
    output logic                  rsp_zero,
    input  logic                  rsp_ready
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state_reg, state_next;

    logic [ID_W-1:0]  ptr_reg;
    logic [ID_W-1:0]  id_reg;
    logic [WIDTH-1:0] op_reg;

    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] masked_valid;
    logic [NREQ-1:0] masked_oh;
    logic [NREQ-1:0] plain_oh;
    logic [NREQ-1:0] grant_oh;
    logic            any_valid;
    logic            accept;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] ptr_next;
    logic [WIDTH-1:0] grant_data;

    logic [NREQ:0][ID_W-1:0]  idx_chain;
    logic [NREQ:0][WIDTH-1:0] data_chain;

    // Requesters at or above the pointer get first pick; if none of them is valid,
    // the search wraps around to the lowest-numbered valid requester.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_arb
            assign hi_mask[gi] = (ID_W'(gi) >= ptr_reg);
            assign idx_chain[gi+1]  = idx_chain[gi]  | (grant_oh[gi] ? ID_W'(gi) : '0);
            assign data_chain[gi+1] = data_chain[gi] |
                                      (grant_oh[gi] ? req_data[gi*WIDTH +: WIDTH] : '0);
        end
    endgenerate

    assign idx_chain[0]  = '0;
    assign data_chain[0] = '0;

    assign masked_valid = req_valid & hi_mask;
    assign masked_oh    = masked_valid & (~masked_valid + NREQ'(1));
    assign plain_oh     = req_valid & (~req_valid + NREQ'(1));
    assign grant_oh     = (|masked_valid) ? masked_oh : plain_oh;
    assign any_valid    = |req_valid;

    assign grant_idx  = idx_chain[NREQ];
    assign grant_data = data_chain[NREQ];
    assign ptr_next   = (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + ID_W'(1);
    assign accept     = (state_reg == IDLE) && any_valid;

    assign neg_a = op_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // rst_n gates req_ready so no grant is visible while reset is held.
    always_comb begin
        state_next = state_reg;
        rsp_valid  = 1'b0;
        req_ready  = '0;
        case (state_reg)
            IDLE: begin
                if (rst_n) begin
                    req_ready = grant_oh;
                end
                if (any_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg  <= '0;
            op_reg   <= '0;
            id_reg   <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            rsp_ovf  <= 1'b0;
            rsp_zero <= 1'b0;
        end else begin
            if (accept) begin
                op_reg  <= grant_data;
                id_reg  <= grant_idx;
                ptr_reg <= ptr_next;
            end
            // The negator output is captured exactly once, at the end of EXEC.
            if (state_reg == EXEC) begin
                rsp_data <= neg_b;
                rsp_ovf  <= (op_reg == {1'b1, {(WIDTH-1){1'b0}}});
                rsp_zero <= (neg_b == '0);
                rsp_id   <= id_reg;
            end
        end
    end

endmodule

// File: doc/twos_comp_arbiter.md
# twos_comp_arbiter

Round-robin arbiter and sequencer that shares a single combinational 16-bit two's complement negation unit (B = ~A + 1) among several requesters in the ALU_2 datapath. It accepts one operand at a time over a valid/ready handshake, presents it to the shared negator, registers the result with status flags, and returns it tagged with the requester ID over a valid/ready response channel. Only one operation is in flight at a time.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width; must match the negation unit
- ID_W, 2, requester ID width = ceil(log2(NREQ))

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_data  in  NREQ*WIDTH  operands; requester i in bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot accept; at most one bit high
- neg_a  out  WIDTH  operand to shared negator
- neg_b  in  WIDTH  combinational result from shared negator
- rsp_valid  out  1  result valid
- rsp_id  out  ID_W  index of requester that owns the result
- rsp_data  out  WIDTH  negated operand
- rsp_ovf  out  1  operand was most-negative value (1 followed by WIDTH-1 zeros); result equals operand
- rsp_zero  out  1  result is zero
- rsp_ready  in  1  consumer accepts result

## Operation
- State machine: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: round-robin search of req_valid starting at pointer ptr, wrapping NREQ-1 -> 0. Winner w gets req_ready[w]=1 combinationally in the same cycle. On that edge: op_reg <= req_data[w], id_reg <= w, ptr <= (w+1) mod NREQ, state -> EXEC. No valid request: req_ready all 0, remain IDLE, ptr unchanged.
- req_ready is 0 in EXEC and RESP regardless of req_valid.
- EXEC: neg_a = op_reg (neg_a always driven from op_reg). On edge: rsp_data <= neg_b, rsp_ovf <= (op_reg == 1<<(WIDTH-1)), rsp_zero <= (neg_b == 0), rsp_id <= id_reg, state -> RESP.
- RESP: rsp_valid=1; rsp_data/id/flags held stable until handshake. rsp_valid && rsp_ready on edge -> IDLE. rsp_ready ignored in other states.
- Arithmetic: modulo 2^WIDTH; no saturation. 0 -> 0 with rsp_zero=1, rsp_ovf=0.
- Requesters must hold req_valid/req_data stable until accepted; the arbiter does not latch unaccepted requests. Deasserting req_valid before acceptance removes that requester from arbitration with no side effect.
- Fairness: a requester continuously asserting req_valid waits at most NREQ-1 other grants.
- Reset (any time, including mid-EXEC or mid-RESP): immediately state=IDLE, ptr=0, op_reg=0, id_reg=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, rsp_zero=0, req_ready=0, neg_a=0. An in-flight operation is dropped; no response is produced for it.

## Timing
- Accept edge (IDLE, req handshake) -> EXEC one cycle -> rsp_valid high starting cycle 2 after accept edge.
- Minimum issue interval: 3 cycles per operation when rsp_ready is held high (accept, exec, response).
- rsp_ready low stalls in RESP indefinitely; no new accept until the response completes.
- req_ready depends combinationally on req_valid and state only; no combinational path from rsp_ready to req_ready.
- neg_b sampled only at the end of EXEC; negator must settle within one cycle.

## Test plan
- Reset: rst_n low mid-RESP with rsp_valid=1 -> all outputs 0 asynchronously, state IDLE, ptr=0; after release, requester 0 with 0x0005 wins first.
- Single request: req 2 presents 0x0001, rsp_ready=1 -> req_ready=0b0100 one cycle, 2 cycles later rsp_valid=1, rsp_data=0xFFFF, rsp_id=2, ovf=0, zero=0.
- Boundaries: operands 0x0000 -> 0x0000 zero=1 ovf=0; 0x8000 -> 0x8000 ovf=1 zero=0; 0x7FFF -> 0x8001 both flags 0.
- Round-robin: all four valid continuously, operands 0x0010..0x0013 -> grant order 0,1,2,3,0; rsp_data 0xFFF0,0xFFEF,0xFFEE,0xFFED; one accept every 3 cycles.
- Backpressure: rsp_ready low 5 cycles in RESP -> rsp_data/id/flags stable, req_ready all 0 while req 1 valid; rsp_ready high -> IDLE next, req 1 granted same cycle.
- Pointer wrap/skip: ptr=3, only req 1 valid -> req 1 granted, ptr becomes 2.
